shake_arbiter: RTL and testbench
================================

SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: RUN cycles allowed before a job is aborted.
REQ-002 Parameter MAX_LEN, default 5376: largest legal output_len in bits.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_i  input  2  request per requester; bit0 = matrix-A path, bit1 = noise/coins path.
REQ-006 in0_i, in1_i  input  256  seed or coins per requester.
REQ-007 dom0_i, dom1_i  input  4  domain bits per requester.
REQ-008 len0_i, len1_i  input  14  output length in bits per requester.
REQ-009 gnt_o  output  2  one-hot, the requester currently owning the core.
REQ-010 ack_o  output  2  one-cycle pulse: job finished, result on rsp_data_o.
REQ-011 err_o  output  2  one-cycle pulse: job rejected or timed out.
REQ-012 rsp_data_o  output  5376  result string, valid only in the ack cycle.
REQ-013 core_rst_o, core_en_o  output  1 each  drive the core's rst and enable.
REQ-014 core_in_o  output  256; core_dom_o  output  4; core_len_o  output  14  core operands.
REQ-015 core_out_i  input  5376; core_done_i  input  1  core result and done.

Function
REQ-016 FSM states: IDLE, CLEAR, RUN, RESP.
REQ-017 IDLE: no request -> stay; one request -> grant it; both -> grant the one not granted last (round-robin; after reset bit0 wins).
REQ-018 On grant, latch the requester's in/dom/len into operand registers; core_*_o come only from these registers.
REQ-019 Latched len of 0 or greater than MAX_LEN -> err_o pulse on the granted bit next cycle, core not started, return to IDLE.
REQ-020 CLEAR: exactly one cycle, core_rst_o=1, core_en_o=0.
REQ-021 RUN: core_rst_o=0, core_en_o=1; watchdog counter starts at 0 and increments every cycle.
REQ-022 core_done_i is sampled only in RUN; done in any other state is ignored.
REQ-023 RUN and core_done_i=1 -> capture core_out_i into rsp_data_o, go to RESP.
REQ-024 RUN and counter = TIMEOUT_CYCLES-1 without done -> err_o pulse, core_rst_o=1 for one cycle, IDLE.
REQ-025 RESP: one cycle; ack_o pulses on the granted bit, core_en_o=0, then IDLE with gnt_o cleared.
REQ-026 gnt_o stays stable from the grant until the ack/err cycle inclusive.
REQ-027 A requester holds req and operands until its ack/err; dropping req mid-job does not abort the job.
REQ-028 Minimum job latency, grant to ack: 1 (CLEAR) + core run time + 1 (RESP) cycles.
REQ-029 ack_o and err_o are never asserted together, and never for more than one cycle.

Reset
REQ-030 rst=1: FSM -> IDLE; gnt_o, ack_o, err_o, core_en_o = 0; core_rst_o = 1; rsp_data_o, operands and counter = 0; round-robin pointer -> requester 0.
REQ-031 rst mid-RUN aborts the job without ack/err; the requester re-requests.

Structure
REQ-032 The state enum, MAX_LEN and the 5376/256/14 width constants belong in a shared package (kyber_pkg), also used by shake128 users.
REQ-033 A single sub-module, rr_arb2 (2-way round-robin grant with a last-grant pointer), is instantiated; shake128 itself is instantiated outside, at the top level.

Verification
REQ-034 req_i=01, len0=1024, seed f8f1...5598, dom 1111 -> one CLEAR cycle, then RUN; ack_o=01, and rsp_data_o equals the standalone shake128 output.
REQ-035 req_i=11 held for two jobs -> grants 01 then 10 (then 01 again if req_i is still 11).
REQ-036 len1=0 or 5377 -> err_o=10 one cycle after the grant; core_en_o never asserted.
REQ-037 Stub core with done never asserted, TIMEOUT_CYCLES=16 -> err_o after 16 RUN cycles, then a core_rst_o pulse, then IDLE.
REQ-038 rst asserted for one cycle mid-RUN -> all outputs at reset values the next cycle, no ack; a re-request completes normally.
REQ-039 core_done_i held high in IDLE -> no spurious ack; the CLEAR cycle lowers done before RUN samples it.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber/SHAKE width constants, the arbiter FSM state type and operand bundle.
package kyber_pkg;
  localparam int SEED_W  = 256;
  localparam int OUT_W   = 5376;
  localparam int LEN_W   = 14;
  localparam int DOM_W   = 4;
  localparam int MAX_LEN = 5376;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_RUN, ST_RESP} arb_state_e;

  typedef struct packed {
    logic [SEED_W-1:0] seed;
    logic [DOM_W-1:0]  dom;
    logic [LEN_W-1:0]  len;
  } op_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; prio names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);
  logic prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

  // After a grant the other requester gets the next tie.
  always_ff @(posedge clk) begin
    if (rst)       prio <= 1'b0;
    else if (take) prio <= gnt[0];
  end
endmodule

// File: rtl/shake_arbiter.sv
// Shares one SHAKE core between two requesters: grant, clear core, run with watchdog, respond.
module shake_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_LEN        = kyber_pkg::MAX_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   req_i,
  input  logic [kyber_pkg::SEED_W-1:0] in0_i,
  input  logic [kyber_pkg::SEED_W-1:0] in1_i,
  input  logic [kyber_pkg::DOM_W-1:0]  dom0_i,
  input  logic [kyber_pkg::DOM_W-1:0]  dom1_i,
  input  logic [kyber_pkg::LEN_W-1:0]  len0_i,
  input  logic [kyber_pkg::LEN_W-1:0]  len1_i,
  output logic [1:0]                   gnt_o,
  output logic [1:0]                   ack_o,
  output logic [1:0]                   err_o,
  output logic [kyber_pkg::OUT_W-1:0]  rsp_data_o,
  output logic                         core_rst_o,
  output logic                         core_en_o,
  output logic [kyber_pkg::SEED_W-1:0] core_in_o,
  output logic [kyber_pkg::DOM_W-1:0]  core_dom_o,
  output logic [kyber_pkg::LEN_W-1:0]  core_len_o,
  input  logic [kyber_pkg::OUT_W-1:0]  core_out_i,
  input  logic                         core_done_i
);
  import kyber_pkg::*;

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        state, state_nxt;
  op_t               op;
  logic [1:0]        gnt, arb_gnt;
  logic              abort, take, len_bad, timeout, done;
  logic [CNT_W-1:0]  cnt;
  logic [OUT_W-1:0]  rsp;

  // The cycle after a timeout is spent in IDLE flagging the error, so no new grant there.
  assign take    = (state == ST_IDLE) && !abort && (req_i != 2'b00);
  assign len_bad = (op.len == '0) || (int'(op.len) > MAX_LEN);
  assign timeout = (cnt == CNT_LAST);
  assign done    = (state == ST_RUN) && core_done_i;

  rr_arb2 u_rr (.clk(clk), .rst(rst), .req(req_i), .take(take), .gnt(arb_gnt));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = len_bad ? ST_IDLE : ST_RUN;
      ST_RUN:   if (done) state_nxt = ST_RESP;
                else if (timeout) state_nxt = ST_IDLE;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op    <= '0;
      gnt   <= '0;
      abort <= 1'b0;
      cnt   <= '0;
      rsp   <= '0;
    end else begin
      abort <= (state == ST_RUN) && !core_done_i && timeout;
      case (state)
        ST_IDLE: begin
          gnt <= take ? arb_gnt : 2'b00;
          if (take) op <= arb_gnt[1] ? op_t'{in1_i, dom1_i, len1_i}
                                     : op_t'{in0_i, dom0_i, len0_i};
        end
        ST_CLEAR: begin
          cnt <= '0;
          if (len_bad) gnt <= 2'b00;
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (core_done_i) rsp <= core_out_i;
        end
        ST_RESP: gnt <= 2'b00;
        default: gnt <= 2'b00;
      endcase
    end
  end

  // The core is parked in reset whenever it is not running or being read out.
  always_comb begin
    gnt_o      = gnt;
    ack_o      = (state == ST_RESP) ? gnt : 2'b00;
    err_o      = (((state == ST_CLEAR) && len_bad) || abort) ? gnt : 2'b00;
    core_en_o  = (state == ST_RUN);
    core_rst_o = (state != ST_RUN) && (state != ST_RESP);
    rsp_data_o = rsp;
    core_in_o  = op.seed;
    core_dom_o = op.dom;
    core_len_o = op.len;
  end
endmodule

// File: tb/tb_shake_arbiter.sv
// Directed bench for shake_arbiter with a counting stub in place of the SHAKE core.
module tb_shake_arbiter;
  import kyber_pkg::*;

  localparam logic [SEED_W-1:0] SEED  = 256'hf8f1a2b3c4d5e6f708192a3b4c5d6e7f8091a2b3c4d5e6f708192a3b4c5d5598;
  localparam logic [SEED_W-1:0] SEED2 = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic              clk, rst;
  logic [1:0]        req_i, gnt_o, ack_o, err_o;
  logic [SEED_W-1:0] in0_i, in1_i, core_in_o;
  logic [DOM_W-1:0]  dom0_i, dom1_i, core_dom_o;
  logic [LEN_W-1:0]  len0_i, len1_i, core_len_o;
  logic [OUT_W-1:0]  rsp_data_o, core_out_i;
  logic              core_rst_o, core_en_o, core_done_i, force_done;
  int                run_len, stub_cnt;
  int                passed = 0, total = 0;

  shake_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i),
    .in0_i(in0_i), .in1_i(in1_i), .dom0_i(dom0_i), .dom1_i(dom1_i),
    .len0_i(len0_i), .len1_i(len1_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o), .rsp_data_o(rsp_data_o),
    .core_rst_o(core_rst_o), .core_en_o(core_en_o),
    .core_in_o(core_in_o), .core_dom_o(core_dom_o), .core_len_o(core_len_o),
    .core_out_i(core_out_i), .core_done_i(core_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] model(input logic [SEED_W-1:0] s,
                                             input logic [DOM_W-1:0] d,
                                             input logic [LEN_W-1:0] l);
    return {21{s ^ {238'b0, d, l}}};
  endfunction

  // Stub core: done after run_len enabled cycles (never when run_len is 0).
  always_ff @(posedge clk) begin
    if (core_rst_o)     stub_cnt <= 0;
    else if (core_en_o) stub_cnt <= stub_cnt + 1;
  end
  assign core_done_i = force_done || (core_en_o && run_len > 0 && stub_cnt == run_len - 1);
  assign core_out_i  = model(core_in_o, core_dom_o, core_len_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered in an IDLE cycle with the request up; leaves in the RESP cycle.
  task automatic job(input string tag, input logic [1:0] g, input logic [OUT_W-1:0] exp);
    tick();
    chk({tag, " clr_gnt"}, 64'(gnt_o), 64'(g));
    chk({tag, " clr_rst"}, 64'(core_rst_o), 64'd1);
    chk({tag, " clr_en"},  64'(core_en_o), 64'd0);
    force_done = 1'b0;
    tick();
    chk({tag, " run_en"},  64'(core_en_o), 64'd1);
    chk({tag, " run_rst"}, 64'(core_rst_o), 64'd0);
    tick();
    tick();
    chk({tag, " run3_ack"}, 64'(ack_o), 64'd0);
    tick();
    chk({tag, " ack"},     64'(ack_o), 64'(g));
    chk({tag, " ack_err"}, 64'(err_o), 64'd0);
    chk({tag, " resp_en"}, 64'(core_en_o), 64'd0);
    chk({tag, " rsp"},     64'(rsp_data_o === exp), 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_i = 2'b00; force_done = 1'b0; run_len = 3;
    in0_i = SEED; dom0_i = 4'hF; len0_i = 14'd1024;
    in1_i = SEED2; dom1_i = 4'h3; len1_i = 14'd5376;
    tick();
    tick();
    chk("rst gnt",      64'(gnt_o), 64'd0);
    chk("rst ack",      64'(ack_o), 64'd0);
    chk("rst err",      64'(err_o), 64'd0);
    chk("rst core_en",  64'(core_en_o), 64'd0);
    chk("rst core_rst", 64'(core_rst_o), 64'd1);
    chk("rst rsp",      64'(rsp_data_o === '0), 64'd1);
    chk("rst len",      64'(core_len_o), 64'd0);
    rst = 1'b0;

    // single job on requester 0
    req_i = 2'b01;
    job("job0", 2'b01, model(SEED, 4'hF, 14'd1024));
    chk("job0 in", 64'(core_in_o[63:0]), SEED[63:0]);
    req_i = 2'b00;
    tick();
    chk("job0 idle_gnt", 64'(gnt_o), 64'd0);
    chk("job0 idle_ack", 64'(ack_o), 64'd0);

    // round robin from a fresh reset, requester 1 at the maximum length
    rst = 1'b1;
    tick();
    chk("rst2 len", 64'(core_len_o), 64'd0);
    rst = 1'b0;
    req_i = 2'b11;
    job("rr_a", 2'b01, model(SEED, 4'hF, 14'd1024));
    tick();
    chk("rr idle_gnt", 64'(gnt_o), 64'd0);
    job("rr_b", 2'b10, model(SEED2, 4'h3, 14'd5376));
    tick();
    tick();
    chk("rr_c gnt", 64'(gnt_o), 64'd1);
    req_i = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    chk("rr_c ack", 64'(ack_o), 64'd1);
    tick();

    // illegal lengths
    len1_i = 14'd0; req_i = 2'b10;
    tick();
    chk("len0 err", 64'(err_o), 64'd2);
    chk("len0 gnt", 64'(gnt_o), 64'd2);
    chk("len0 en",  64'(core_en_o), 64'd0);
    req_i = 2'b00;
    tick();
    chk("len0 err_drop", 64'(err_o), 64'd0);
    chk("len0 gnt_drop", 64'(gnt_o), 64'd0);
    chk("len0 en2",      64'(core_en_o), 64'd0);
    len1_i = 14'd5377; req_i = 2'b10;
    tick();
    chk("len5377 err", 64'(err_o), 64'd2);
    chk("len5377 len", 64'(core_len_o), 64'd5377);
    chk("len5377 en",  64'(core_en_o), 64'd0);
    req_i = 2'b00;
    tick();
    chk("len5377 err_drop", 64'(err_o), 64'd0);

    // watchdog: 16 RUN cycles without done
    run_len = 0; req_i = 2'b01;
    tick();
    chk("wd clear_en", 64'(core_en_o), 64'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("wd run_en",  64'(core_en_o), 64'd1);
      chk("wd run_err", 64'(err_o), 64'd0);
    end
    tick();
    chk("wd err",      64'(err_o), 64'd1);
    chk("wd gnt",      64'(gnt_o), 64'd1);
    chk("wd core_rst", 64'(core_rst_o), 64'd1);
    chk("wd en",       64'(core_en_o), 64'd0);
    chk("wd ack",      64'(ack_o), 64'd0);
    req_i = 2'b00;
    tick();
    chk("wd err_drop", 64'(err_o), 64'd0);
    chk("wd gnt_drop", 64'(gnt_o), 64'd0);
    run_len = 3;

    // reset in the middle of RUN, then the same request completes
    len1_i = 14'd64; req_i = 2'b10;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst gnt",      64'(gnt_o), 64'd0);
    chk("midrst ack",      64'(ack_o), 64'd0);
    chk("midrst err",      64'(err_o), 64'd0);
    chk("midrst en",       64'(core_en_o), 64'd0);
    chk("midrst core_rst", 64'(core_rst_o), 64'd1);
    chk("midrst rsp",      64'(rsp_data_o === '0), 64'd1);
    rst = 1'b0;
    job("rerun", 2'b10, model(SEED2, 4'h3, 14'd64));
    req_i = 2'b00;
    tick();

    // done held high while idle and through CLEAR must not be taken
    force_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_done ack", 64'(ack_o), 64'd0);
      chk("idle_done gnt", 64'(gnt_o), 64'd0);
    end
    req_i = 2'b01;
    job("done_idle", 2'b01, model(SEED, 4'hF, 14'd1024));
    req_i = 2'b00;
    tick();
    chk("done_idle end", 64'(gnt_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
